spike_readout: RTL and testbench

Output-side decoder for a spiking layer. It consumes the layer's parallel `spike_out` vector on the same `clk`/`ce` tick, counts spikes per neuron over a programmable window of ticks, then scans the counts sequentially to report the winning neuron index through a valid/ready handshake. It sits directly after the neuron layer and turns rate-coded spike trains into a class decision.

---
 rtl/snn_pkg.sv | 22 ++
 rtl/sat_counter.sv | 24 ++
 rtl/spike_readout.sv | 164 ++++++++++++++++
 tb/tb_spike_readout.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// Shared SNN package: readout FSM state type and the saturating-increment helper
// used by the spike counters in this design.
package snn_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        SCAN,
        HOLD
    } readout_state_t;

    localparam int SAT_MAX_W = 32;

    // Increment val, sticking at the all-ones value of a width-bit counter.
    function automatic logic [SAT_MAX_W-1:0] sat_inc(input logic [SAT_MAX_W-1:0] val,
                                                     input int unsigned          width);
        logic [SAT_MAX_W-1:0] max_val;
        max_val = (SAT_MAX_W'(1) << width) - SAT_MAX_W'(1);
        return (val >= max_val) ? val : val + SAT_MAX_W'(1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear takes priority over enable.
module sat_counter
    import snn_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= CNT_W'(sat_inc(SAT_MAX_W'(cnt), CNT_W));
        end
    end

endmodule

// File: rtl/spike_readout.sv
// Rate-code readout: counts spikes per neuron over a window, then scans for the winner.
// Optional build macro SPIKE_READOUT_TOTAL_EN adds the total_count output.
module spike_readout
    import snn_pkg::*;
#(
    parameter  int NEURON_NUM = 64,
    parameter  int CNT_W      = 8,
    parameter  int WINDOW_W   = 8,
    localparam int IDX_W      = (NEURON_NUM > 1) ? $clog2(NEURON_NUM) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce,
    input  logic                  start,
    input  logic [WINDOW_W-1:0]   window_len,
    input  logic [NEURON_NUM-1:0] spike_in,
    output logic                  busy,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [IDX_W-1:0]      winner,
    output logic [CNT_W-1:0]      winner_count,
`ifdef SPIKE_READOUT_TOTAL_EN
    output logic [CNT_W+IDX_W-1:0] total_count,
`endif
    output logic                  tie
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NEURON_NUM - 1);

    readout_state_t      state;
    logic [WINDOW_W-1:0] win_len;
    logic [WINDOW_W-1:0] tick_cnt;
    logic [WINDOW_W-1:0] tick_nxt;
    logic [IDX_W-1:0]    scan_idx;
    logic [IDX_W-1:0]    run_idx;
    logic [CNT_W-1:0]    run_max;
    logic                run_tie;

    logic                cnt_clr;
    logic [NEURON_NUM-1:0] cnt_en;
    logic [CNT_W-1:0]    cnt_arr [NEURON_NUM];

    logic [CNT_W-1:0]    cur_cnt;
    logic [CNT_W-1:0]    nxt_max;
    logic [IDX_W-1:0]    nxt_idx;
    logic                nxt_tie;

    assign cnt_clr  = (state == IDLE) && start;
    assign tick_nxt = tick_cnt + WINDOW_W'(1);

    for (genvar i = 0; i < NEURON_NUM; i++) begin : g_cnt
        assign cnt_en[i] = (state == ACCUM) && ce && spike_in[i];

        sat_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk (clk),
            .rst (rst),
            .clr (cnt_clr),
            .en  (cnt_en[i]),
            .cnt (cnt_arr[i])
        );
    end

    // Index 0 seeds the running max; later indices only win on a strictly greater count.
    always_comb begin
        cur_cnt = cnt_arr[scan_idx];
        nxt_max = run_max;
        nxt_idx = run_idx;
        nxt_tie = run_tie;
        if (scan_idx == '0) begin
            nxt_max = cur_cnt;
            nxt_idx = '0;
            nxt_tie = 1'b0;
        end else if (cur_cnt > run_max) begin
            nxt_max = cur_cnt;
            nxt_idx = scan_idx;
            nxt_tie = 1'b0;
        end else if (cur_cnt == run_max) begin
            nxt_tie = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            win_len      <= '0;
            tick_cnt     <= '0;
            scan_idx     <= '0;
            run_idx      <= '0;
            run_max      <= '0;
            run_tie      <= 1'b0;
            busy         <= 1'b0;
            out_valid    <= 1'b0;
            winner       <= '0;
            winner_count <= '0;
            tie          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        win_len  <= window_len;
                        tick_cnt <= '0;
                        scan_idx <= '0;
                        busy     <= 1'b1;
                        state    <= (window_len == '0) ? SCAN : ACCUM;
                    end
                end
                ACCUM: begin
                    if (ce) begin
                        tick_cnt <= tick_nxt;
                        if (tick_nxt == win_len) begin
                            state <= SCAN;
                        end
                    end
                end
                SCAN: begin
                    run_max  <= nxt_max;
                    run_idx  <= nxt_idx;
                    run_tie  <= nxt_tie;
                    scan_idx <= scan_idx + IDX_W'(1);
                    if (scan_idx == LAST_IDX) begin
                        winner       <= nxt_idx;
                        winner_count <= nxt_max;
                        tie          <= nxt_tie;
                        out_valid    <= 1'b1;
                        busy         <= 1'b0;
                        state        <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SPIKE_READOUT_TOTAL_EN
    localparam int TOT_W = CNT_W + IDX_W;

    logic [TOT_W-1:0] run_sum;
    logic [TOT_W-1:0] nxt_sum;

    assign nxt_sum = ((scan_idx == '0) ? '0 : run_sum) + TOT_W'(cur_cnt);

    // The sum is only published with the other results so it stays stable in HOLD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_sum     <= '0;
            total_count <= '0;
        end else if (state == SCAN) begin
            run_sum <= nxt_sum;
            if (scan_idx == LAST_IDX) begin
                total_count <= nxt_sum;
            end
        end
    end
`endif

endmodule

// File: tb/tb_spike_readout.sv
// Bench for spike_readout: two instances (CNT_W=4 and CNT_W=3) on shared stimulus,
// checked every cycle against a window/argmax model plus directed literal checks.
module tb_spike_readout;

    localparam int NN = 8;
    localparam int WW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ce = 1'b0;
    logic          start = 1'b0;
    logic          out_ready = 1'b0;
    logic [WW-1:0] window_len = '0;
    logic [NN-1:0] spike_in = '0;

    logic       a_busy, a_valid, a_tie;
    logic [2:0] a_winner;
    logic [3:0] a_wcnt;
    logic       b_busy, b_valid, b_tie;
    logic [2:0] b_winner;
    logic [2:0] b_wcnt;
`ifdef SPIKE_READOUT_TOTAL_EN
    logic [6:0] a_total;
    logic [5:0] b_total;
`endif

    spike_readout #(.NEURON_NUM(NN), .CNT_W(4), .WINDOW_W(WW)) dut_a (
        .clk          (clk),
        .rst          (rst),
        .ce           (ce),
        .start        (start),
        .window_len   (window_len),
        .spike_in     (spike_in),
        .busy         (a_busy),
        .out_valid    (a_valid),
        .out_ready    (out_ready),
        .winner       (a_winner),
        .winner_count (a_wcnt),
`ifdef SPIKE_READOUT_TOTAL_EN
        .total_count  (a_total),
`endif
        .tie          (a_tie)
    );

    spike_readout #(.NEURON_NUM(NN), .CNT_W(3), .WINDOW_W(WW)) dut_b (
        .clk          (clk),
        .rst          (rst),
        .ce           (ce),
        .start        (start),
        .window_len   (window_len),
        .spike_in     (spike_in),
        .busy         (b_busy),
        .out_valid    (b_valid),
        .out_ready    (out_ready),
        .winner       (b_winner),
        .winner_count (b_wcnt),
`ifdef SPIKE_READOUT_TOTAL_EN
        .total_count  (b_total),
`endif
        .tie          (b_tie)
    );

    initial forever #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: index 0 is the CNT_W=4 instance, index 1 the CNT_W=3 instance.
    int m_cnt [2][NN];
    int m_win, m_ticks, m_scan_left;
    bit m_acc, m_hold;
    int m_winner [2];
    int m_wcnt [2];
    int m_tie [2];
    int m_total [2];

    function automatic int lim(input int d);
        return (d == 0) ? 15 : 7;
    endfunction

    task automatic model_resolve();
        for (int d = 0; d < 2; d++) begin
            int mx, first, neq, sum;
            mx = 0; first = -1; neq = 0; sum = 0;
            for (int i = 0; i < NN; i++) if (m_cnt[d][i] > mx) mx = m_cnt[d][i];
            for (int i = 0; i < NN; i++) begin
                sum += m_cnt[d][i];
                if (m_cnt[d][i] == mx) begin
                    neq++;
                    if (first < 0) first = i;
                end
            end
            m_winner[d] = first;
            m_wcnt[d]   = mx;
            m_tie[d]    = (neq > 1) ? 1 : 0;
            m_total[d]  = sum;
        end
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_acc = 0; m_hold = 0; m_scan_left = 0; m_win = 0; m_ticks = 0;
            for (int d = 0; d < 2; d++) begin
                m_winner[d] = 0; m_wcnt[d] = 0; m_tie[d] = 0; m_total[d] = 0;
                for (int i = 0; i < NN; i++) m_cnt[d][i] = 0;
            end
        end else if (m_hold) begin
            if (out_ready) m_hold = 0;
        end else if (m_scan_left > 0) begin
            m_scan_left--;
            if (m_scan_left == 0) begin
                model_resolve();
                m_hold = 1;
            end
        end else if (m_acc) begin
            if (ce) begin
                for (int d = 0; d < 2; d++)
                    for (int i = 0; i < NN; i++)
                        if (spike_in[i] && m_cnt[d][i] < lim(d)) m_cnt[d][i]++;
                m_ticks++;
                if (m_ticks == m_win) begin
                    m_acc = 0;
                    m_scan_left = NN;
                end
            end
        end else if (start) begin
            for (int d = 0; d < 2; d++)
                for (int i = 0; i < NN; i++) m_cnt[d][i] = 0;
            m_win = int'(window_len);
            m_ticks = 0;
            if (m_win == 0) m_scan_left = NN;
            else m_acc = 1;
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("a.busy",      a_busy,   int'(m_acc || m_scan_left > 0));
            check("a.out_valid", a_valid,  int'(m_hold));
            check("a.winner",    a_winner, m_winner[0]);
            check("a.win_count", a_wcnt,   m_wcnt[0]);
            check("a.tie",       a_tie,    m_tie[0]);
            check("b.busy",      b_busy,   int'(m_acc || m_scan_left > 0));
            check("b.out_valid", b_valid,  int'(m_hold));
            check("b.winner",    b_winner, m_winner[1]);
            check("b.win_count", b_wcnt,   m_wcnt[1]);
            check("b.tie",       b_tie,    m_tie[1]);
`ifdef SPIKE_READOUT_TOTAL_EN
            check("a.total",     a_total,  m_total[0]);
            check("b.total",     b_total,  m_total[1]);
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start cycle carries all-ones spikes with ce high; none of them may count.
    task automatic start_window(input int wl);
        start = 1'b1;
        window_len = WW'(wl);
        spike_in = '1;
        ce = 1'b1;
        tick();
        start = 1'b0;
        spike_in = '0;
    endtask

    task automatic wait_valid(output int k);
        k = 0;
        while (!a_valid && k < 100) begin
            tick();
            k++;
        end
        check("wait.out_valid", a_valid, 1);
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("hs.out_valid_low", a_valid, 0);
    endtask

    task automatic expect_result(input string tag, input int w, input int wc, input int t,
                                 input int bw, input int bwc, input int bt);
        check({tag, ".a.winner"}, a_winner, w);
        check({tag, ".a.win_count"}, a_wcnt, wc);
        check({tag, ".a.tie"}, a_tie, t);
        check({tag, ".b.winner"}, b_winner, bw);
        check({tag, ".b.win_count"}, b_wcnt, bwc);
        check({tag, ".b.tie"}, b_tie, bt);
    endtask

    initial begin
        int k;
        int cnt;

        tick();
        chk_en = 1'b1;
        check("rst.out_valid", a_valid, 0);
        check("rst.busy", a_busy, 0);
        check("rst.winner", a_winner, 0);
        check("rst.win_count", a_wcnt, 0);
        tick();
        rst = 1'b0;
        tick();

        // Neuron 3 on all 5 ticks, neuron 1 on the first 2.
        start_window(5);
        check("t1.busy_rise", a_busy, 1);
        for (int t = 0; t < 5; t++) begin
            spike_in = 8'h08 | ((t < 2) ? 8'h02 : 8'h00);
            tick();
        end
        spike_in = '0;
        wait_valid(k);
        check("t1.latency", k, 8);
        expect_result("t1", 3, 5, 0, 3, 5, 0);
        check("t1.model_winner", m_winner[0], 3);
        check("t1.model_count", m_wcnt[0], 5);
`ifdef SPIKE_READOUT_TOTAL_EN
        check("t1.a.total", a_total, 7);
`endif
        handshake();

        // Neurons 2 and 6 each on 4 of 6 ticks, with two ce-low all-spike cycles.
        start_window(6);
        cnt = 0;
        for (int c = 0; c < 8; c++) begin
            if (c == 3 || c == 5) begin
                ce = 1'b0;
                spike_in = '1;
            end else begin
                ce = 1'b1;
                spike_in = ((cnt < 4) ? 8'h04 : 8'h00) | ((cnt >= 2) ? 8'h40 : 8'h00);
                cnt++;
            end
            tick();
        end
        ce = 1'b1;
        spike_in = '0;
        wait_valid(k);
        expect_result("t2", 2, 4, 1, 2, 4, 1);
        handshake();

        // Zero-length window.
        start_window(0);
        check("t5.busy", a_busy, 1);
        wait_valid(k);
        check("t5.latency", k, 8);
        expect_result("t5", 0, 0, 1, 0, 0, 1);
`ifdef SPIKE_READOUT_TOTAL_EN
        check("t5.a.total", a_total, 0);
`endif
        handshake();

        // All neurons every tick for 10 ticks: CNT_W=3 instance saturates at 7.
        start_window(10);
        spike_in = '1;
        repeat (10) tick();
        spike_in = '0;
        wait_valid(k);
        expect_result("t3", 0, 10, 1, 0, 7, 1);
        check("t3.model_sat", m_wcnt[1], 7);
`ifdef SPIKE_READOUT_TOTAL_EN
        check("t3.a.total", a_total, 80);
        check("t3.b.total", b_total, 56);
`endif

        // Stall in HOLD with start pulses and noisy spikes.
        for (int c = 0; c < 10; c++) begin
            out_ready = 1'b0;
            start = c[0];
            window_len = 4'd3;
            spike_in = 8'($urandom);
            tick();
            check("t4.hold_valid", a_valid, 1);
            check("t4.hold_busy", a_busy, 0);
            check("t4.hold_winner", a_winner, 0);
            check("t4.hold_count", a_wcnt, 10);
        end
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        out_ready = 1'b0;
        start = 1'b0;
        check("t4.release_valid", a_valid, 0);
        check("t4.release_busy", a_busy, 0);
        tick();
        check("t4.no_start_busy", a_busy, 0);

        // Reset mid-window, then a fresh 3-tick window with neuron 5 only.
        start_window(8);
        spike_in = '1;
        repeat (3) tick();
        rst = 1'b1;
        #1;
        check("t6.rst_busy", a_busy, 0);
        check("t6.rst_valid", a_valid, 0);
        check("t6.rst_winner", a_winner, 0);
        check("t6.rst_count", a_wcnt, 0);
        check("t6.rst_tie", a_tie, 0);
        tick();
        rst = 1'b0;
        spike_in = '0;
        tick();
        start_window(3);
        spike_in = 8'h20;
        repeat (3) tick();
        spike_in = '0;
        wait_valid(k);
        expect_result("t6", 5, 3, 0, 5, 3, 0);
`ifdef SPIKE_READOUT_TOTAL_EN
        check("t6.a.total", a_total, 3);
`endif
        handshake();

        // Random traffic with occasional resets, checked by the model every cycle.
        for (int c = 0; c < 2500; c++) begin
            start      = ($urandom_range(0, 3) == 0);
            window_len = WW'($urandom_range(0, 15));
            ce         = ($urandom_range(0, 3) != 0);
            spike_in   = 8'($urandom);
            out_ready  = ($urandom_range(0, 2) == 0);
            rst        = ($urandom_range(0, 399) == 0);
            tick();
        end
        rst = 1'b0;
        start = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
